// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c_master between the camera sequencer (0) and the aux/EEPROM port (1).
// Grant two ticks after a start pulse; a gap follows every transaction; a launch the master never accepts is aborted.
module i2c_arbiter #(
   parameter int GAP_TICKS      = 100,
   parameter int LAUNCH_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clk_en,
   input  logic [1:0] req_start,
   input  logic [6:0] req_addr0,
   input  logic [6:0] req_addr1,
   input  logic       req_rw0,
   input  logic       req_rw1,
   input  logic [4:0] req_packets0,
   input  logic [4:0] req_packets1,
   input  logic [7:0] req_data0,
   input  logic [7:0] req_data1,
   output logic [1:0] req_ready,
   output logic [1:0] req_data_req,
   output logic [1:0] req_data_ready,
   output logic [7:0] req_data_out,
   output logic       m_start,
   output logic [6:0] m_addr,
   output logic       m_rw,
   output logic [4:0] m_packets,
   output logic [7:0] m_data,
   input  logic       m_ready,
   input  logic       m_data_req,
   input  logic       m_data_ready,
   input  logic [7:0] m_data_out,
   output logic [1:0] grant,
   output logic       busy,
   output logic [1:0] error
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LAUNCH = 2'd1;
   localparam logic [1:0] S_BUSY   = 2'd2;
   localparam logic [1:0] S_GAP    = 2'd3;

   localparam int LW = $clog2(LAUNCH_TIMEOUT + 1);
   localparam int GW = $clog2(GAP_TICKS + 1);
   localparam logic [LW-1:0] LCNT_LAST = LW'(LAUNCH_TIMEOUT - 1);
   localparam logic [GW-1:0] GCNT_LAST = GW'(GAP_TICKS - 1);

   logic [1:0]    r_state;
   logic [1:0]    r_pending;
   logic [1:0]    r_grant;
   logic [1:0]    r_error;
   logic          r_last;
   logic          r_m_start;
   logic [LW-1:0] r_lcnt;
   logic [GW-1:0] r_gcnt;

   logic [1:0]    w_new_req;
   logic [1:0]    w_pend_nxt;
   logic          w_win;
   logic [1:0]    w_win_mask;
   logic [1:0]    w_own_mask;

   // A requester that is already pending or owns the bus cannot queue a second start.
   assign w_new_req  = req_start & ~r_pending & ~r_grant;
   assign w_pend_nxt = r_pending | w_new_req;
   assign w_win      = (r_pending == 2'b11) ? ~r_last : r_pending[1];
   assign w_win_mask = w_win ? 2'b10 : 2'b01;
   assign w_own_mask = r_last ? 2'b10 : 2'b01;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_pending <= 2'b00;
         r_grant   <= 2'b00;
         r_error   <= 2'b00;
         r_last    <= 1'b1;
         r_m_start <= 1'b0;
         r_lcnt    <= '0;
         r_gcnt    <= '0;
      end else if (clk_en) begin
         r_pending <= w_pend_nxt;
         case (r_state)
            S_IDLE: begin
               if (m_ready && (r_pending != 2'b00)) begin
                  r_grant   <= w_win_mask;
                  r_last    <= w_win;
                  r_m_start <= 1'b1;
                  r_lcnt    <= '0;
                  r_state   <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               if (!m_ready) begin
                  r_m_start <= 1'b0;
                  r_state   <= S_BUSY;
               end else if (r_lcnt == LCNT_LAST) begin
                  r_error   <= r_error | w_own_mask;
                  r_pending <= w_pend_nxt & ~w_own_mask;
                  r_m_start <= 1'b0;
                  r_grant   <= 2'b00;
                  r_gcnt    <= '0;
                  r_state   <= S_GAP;
               end else begin
                  r_lcnt <= r_lcnt + LW'(1);
               end
            end
            S_BUSY: begin
               if (m_ready) begin
                  r_pending <= w_pend_nxt & ~w_own_mask;
                  r_grant   <= 2'b00;
                  r_gcnt    <= '0;
                  r_state   <= S_GAP;
               end
            end
            default: begin
               r_gcnt <= r_gcnt + GW'(1);
               if (r_gcnt == GCNT_LAST) begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   always_comb begin
      m_addr    = 7'd0;
      m_rw      = 1'b0;
      m_packets = 5'd0;
      m_data    = 8'd0;
      if (r_grant[0]) begin
         m_addr    = req_addr0;
         m_rw      = req_rw0;
         m_packets = req_packets0;
         m_data    = req_data0;
      end else if (r_grant[1]) begin
         m_addr    = req_addr1;
         m_rw      = req_rw1;
         m_packets = req_packets1;
         m_data    = req_data1;
      end
   end

   assign req_ready      = ~r_pending & ~r_grant;
   assign req_data_req   = {2{m_data_req}} & r_grant;
   assign req_data_ready = {2{m_data_ready}} & r_grant;
   assign req_data_out   = m_data_out;
   assign m_start        = r_m_start;
   assign grant          = r_grant;
   assign busy           = (r_state != S_IDLE);
   assign error          = r_error;

endmodule
